mc_hs_controller: RTL and testbench

Multicycle RV32I control unit with a memory ready handshake. It drives the existing multicycle datapath (PC, unified memory, instruction/old-PC registers, register file, ALU, result mux) and adds wait states on every memory access for variable-latency memory. It also adds an access-timeout trap and a parametrised retired-instruction counter. It replaces the fixed-latency controller in the core top.

---
 rtl/mc_hs_controller.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_mc_hs_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_hs_controller.sv
// Multicycle RV32I control FSM. It inserts memory wait states through a ready handshake,
// traps on illegal opcodes or access timeouts, and counts retired instructions.
module mc_hs_controller #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 8,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic                 zero,
  input  logic                 negative,
  input  logic                 overflow,
  input  logic                 carry,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 pc_write,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrca,
  output logic [1:0]           ALUSrcb,
  output logic [3:0]           ALUControl,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_JALR2    = 4'd11;
  localparam logic [3:0] S_BRANCH   = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_AUIPC    = 4'd14;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  logic [3:0]           state_r;
  logic [3:0]           next_state_s;
  logic [CNT_W-1:0]     wait_cnt_r;
  logic [INSTRET_W-1:0] instret_r;
  logic                 trap_r;
  logic [1:0]           trap_cause_r;
  logic [1:0]           next_cause_s;
  logic [6:0]           opcode_s;
  logic [2:0]           funct3_s;
  logic                 funct7b5_s;
  logic                 mem_state_s;
  logic                 timeout_s;
  logic                 retire_s;
  logic                 branch_bad_s;
  logic                 unused_instr_s;

  logic                 mem_req_s;
  logic                 pc_write_s;
  logic                 adr_src_s;
  logic                 mem_write_s;
  logic                 ir_write_s;
  logic                 reg_write_s;
  logic [1:0]           result_src_s;
  logic [1:0]           alu_src_a_s;
  logic [1:0]           alu_src_b_s;
  logic [3:0]           alu_control_s;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_en,
                                            input logic sra_en);
    logic [3:0] op;
    case (f3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // carry=1 means no borrow, so unsigned less-than is !carry
  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                        input logic v, input logic c);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = ~z;
      3'b100:  t = n ^ v;
      3'b101:  t = ~(n ^ v);
      3'b110:  t = ~c;
      3'b111:  t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign opcode_s       = instruction[6:0];
  assign funct3_s       = instruction[14:12];
  assign funct7b5_s     = instruction[30];
  assign unused_instr_s = ^{instruction[31], instruction[29:15], instruction[11:7]};
  assign branch_bad_s   = (funct3_s == 3'b010) || (funct3_s == 3'b011);
  assign mem_state_s    = (state_r == S_FETCH) || (state_r == S_MEMREAD) ||
                          (state_r == S_MEMWRITE);
  assign timeout_s      = (TIMEOUT != 0) && !mem_ready &&
                          (wait_cnt_r == CNT_W'(TIMEOUT));
  assign retire_s       = (next_state_s == S_FETCH) &&
                          ((state_r == S_MEMWB) || (state_r == S_MEMWRITE) ||
                           (state_r == S_ALUWB) || (state_r == S_BRANCH));

  // Next-state and trap-cause selection.
  always_comb begin
    next_state_s = state_r;
    next_cause_s = trap_cause_r;
    case (state_r)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          if (state_r == S_FETCH) begin
            next_state_s = S_DECODE;
          end else if (state_r == S_MEMREAD) begin
            next_state_s = S_MEMWB;
          end else begin
            next_state_s = S_FETCH;
          end
        end else if (timeout_s) begin
          next_state_s = S_TRAP;
          next_cause_s = CAUSE_TIMEOUT;
        end else begin
          next_state_s = state_r;
        end
      end
      S_DECODE: begin
        case (opcode_s)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECR;
          OP_ITYPE:          next_state_s = S_EXECI;
          OP_JAL:            next_state_s = S_JAL;
          OP_JALR:           next_state_s = S_JALR;
          OP_BRANCH:         next_state_s = S_BRANCH;
          OP_LUI:            next_state_s = S_LUI;
          OP_AUIPC:          next_state_s = S_AUIPC;
          default: begin
            next_state_s = S_TRAP;
            next_cause_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode_s[5]) begin
          next_state_s = S_MEMWRITE;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMWB:                   next_state_s = S_FETCH;
      S_EXECR, S_EXECI:          next_state_s = S_ALUWB;
      S_ALUWB:                   next_state_s = S_FETCH;
      S_JAL, S_JALR2:            next_state_s = S_ALUWB;
      S_JALR:                    next_state_s = S_JALR2;
      S_LUI, S_AUIPC:            next_state_s = S_ALUWB;
      S_BRANCH: begin
        if (branch_bad_s) begin
          next_state_s = S_TRAP;
          next_cause_s = CAUSE_ILLEGAL;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_TRAP:                    next_state_s = S_TRAP;
      default:                   next_state_s = S_FETCH;
    endcase
  end

  // Moore output decode; only IRWrite/FETCH pc_write and BRANCH pc_write look at inputs.
  always_comb begin
    mem_req_s     = 1'b0;
    pc_write_s    = 1'b0;
    adr_src_s     = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    result_src_s  = 2'b00;
    alu_src_a_s   = 2'b00;
    alu_src_b_s   = 2'b00;
    alu_control_s = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_s   = 2'b10;
        alu_control_s = alu_decode(funct3_s, funct7b5_s, funct7b5_s);
      end
      S_EXECI: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = 2'b01;
        alu_control_s = alu_decode(funct3_s, 1'b0, funct7b5_s);
      end
      S_ALUWB:  reg_write_s = 1'b1;
      S_JAL, S_JALR2: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
      end
      S_JALR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a_s   = 2'b10;
        alu_control_s = ALU_SUB;
        pc_write_s    = branch_taken(funct3_s, zero, negative, overflow, carry);
      end
      S_LUI: begin
        alu_src_a_s = 2'b11;
        alu_src_b_s = 2'b01;
      end
      S_AUIPC: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_TRAP:   mem_req_s = 1'b0;
      default:  mem_req_s = 1'b0;
    endcase
  end

  // State register and sticky trap status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_FETCH;
      trap_r       <= 1'b0;
      trap_cause_r <= 2'b00;
    end else begin
      state_r <= next_state_s;
      if (next_state_s == S_TRAP) begin
        trap_r       <= 1'b1;
        trap_cause_r <= next_cause_s;
      end
    end
  end

  // Per-access wait counter: cleared on every state change, saturating while memory stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= '0;
    end else if (mem_state_s && !mem_ready && (wait_cnt_r != '1)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= '0;
    end else if (retire_s) begin
      instret_r <= instret_r + INSTRET_W'(1);
    end
  end

  assign mem_req    = mem_req_s   & ~reset;
  assign pc_write   = pc_write_s  & ~reset;
  assign MemWrite   = mem_write_s & ~reset;
  assign IRWrite    = ir_write_s  & ~reset;
  assign RegWrite   = reg_write_s & ~reset;
  assign AdrSrc     = adr_src_s;
  assign ResultSrc  = result_src_s;
  assign ALUSrca    = alu_src_a_s;
  assign ALUSrcb    = alu_src_b_s;
  assign ALUControl = alu_control_s;
  assign trap       = trap_r;
  assign trap_cause = trap_cause_r;
  assign instret    = instret_r;
  assign state      = state_r;

endmodule

// File: tb/tb_mc_hs_controller.sv
// Self-checking bench for mc_hs_controller: directed vectors, corner sequences and
// randomized instruction streams against an instruction-level cycle model.
module tb_mc_hs_controller;
  localparam int TIMEOUT   = 4;
  localparam int CNT_W     = 8;
  localparam int INSTRET_W = 2;

  localparam logic [3:0] A_ADD = 4'b0000;
  localparam logic [3:0] A_SUB = 4'b0001;

  logic clk = 1'b0;
  logic reset, zero, negative, overflow, carry, mem_ready;
  logic [31:0] instruction;
  logic mem_req, pc_write, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
  logic [1:0] ResultSrc, ALUSrca, ALUSrcb, trap_cause;
  logic [3:0] ALUControl, state;
  logic [INSTRET_W-1:0] instret;

  always #5 clk = ~clk;

  mc_hs_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .INSTRET_W(INSTRET_W)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
    .negative(negative), .overflow(overflow), .carry(carry), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_write(pc_write), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrca(ALUSrca),
    .ALUSrcb(ALUSrcb), .ALUControl(ALUControl), .trap(trap), .trap_cause(trap_cause),
    .instret(instret), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction-level model: each instruction expands into the list of cycles it should take.
  typedef struct {
    logic        rdy;
    logic [20:0] outs;
  } cyc_t;

  cyc_t q[$];
  int   m_instret;
  logic m_trap;
  logic [1:0] m_cause;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [20:0] obs();
    return {mem_req, pc_write, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
            ALUSrca, ALUSrcb, ALUControl, trap, trap_cause, instret};
  endfunction

  function automatic void push(logic rdy, logic mreq, logic pcw, logic adr, logic mw,
                               logic irw, logic rw, logic [1:0] res, logic [1:0] sa,
                               logic [1:0] sb, logic [3:0] alu);
    cyc_t c;
    c.rdy  = rdy;
    c.outs = {mreq, pcw, adr, mw, irw, rw, res, sa, sb, alu, m_trap, m_cause,
              INSTRET_W'(m_instret)};
    q.push_back(c);
  endfunction

  function automatic void ctl(logic pcw, logic rw, logic [1:0] res, logic [1:0] sa,
                              logic [1:0] sb, logic [3:0] alu);
    push(rnd(), 1'b0, pcw, 1'b0, 1'b0, 1'b0, rw, res, sa, sb, alu);
  endfunction

  function automatic void retire();
    m_instret = (m_instret + 1) % (1 << INSTRET_W);
  endfunction

  function automatic void aluwb();
    ctl(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, A_ADD);
    retire();
  endfunction

  // kind: 0 fetch, 1 read, 2 write; stall cycle k holds wait count k
  function automatic bit mem_access(int kind, int delay);
    for (int k = 0; k <= TIMEOUT; k++) begin
      logic rdy;
      rdy = (k == delay);
      push(rdy, 1'b1, (kind == 0) && rdy, kind != 0, kind == 2, (kind == 0) && rdy, 1'b0,
           (kind == 0) ? 2'b10 : 2'b00, 2'b00, (kind == 0) ? 2'b10 : 2'b00, A_ADD);
      if (rdy) return 1'b1;
    end
    m_trap  = 1'b1;
    m_cause = 2'b10;
    return 1'b0;
  endfunction

  function automatic logic [3:0] alu_of(logic [2:0] f3, logic sub, logic sra);
    logic [3:0] base [8];
    base = '{4'b0000, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0011, 4'b0010};
    if (f3 == 3'd0 && sub) return A_SUB;
    if (f3 == 3'd5 && sra) return 4'b0111;
    return base[f3];
  endfunction

  function automatic logic taken(logic [2:0] f3, logic [3:0] fl);
    logic z, n, v, c;
    {z, n, v, c} = fl;
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n != v;
      3'd5: return n == v;
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void build(logic [31:0] ins, logic [3:0] fl, int df, int dm);
    logic [6:0] op;
    logic [2:0] f3;
    logic b30;
    op  = ins[6:0];
    f3  = ins[14:12];
    b30 = ins[30];
    if (!mem_access(0, df)) return;
    ctl(1'b0, 1'b0, 2'b00, 2'b01, 2'b01, A_ADD);
    case (op)
      7'h03, 7'h23: begin
        ctl(1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_ADD);
        if (op == 7'h23) begin
          if (!mem_access(2, dm)) return;
        end else begin
          if (!mem_access(1, dm)) return;
          ctl(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, A_ADD);
        end
        retire();
      end
      7'h33: begin ctl(1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu_of(f3, b30, b30)); aluwb(); end
      7'h13: begin ctl(1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu_of(f3, 1'b0, b30)); aluwb(); end
      7'h6F: begin ctl(1'b1, 1'b0, 2'b00, 2'b01, 2'b10, A_ADD); aluwb(); end
      7'h67: begin
        ctl(1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_ADD);
        ctl(1'b1, 1'b0, 2'b00, 2'b01, 2'b10, A_ADD);
        aluwb();
      end
      7'h63: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          ctl(1'b0, 1'b0, 2'b00, 2'b10, 2'b00, A_SUB);
          m_trap  = 1'b1;
          m_cause = 2'b01;
        end else begin
          ctl(taken(f3, fl), 1'b0, 2'b00, 2'b10, 2'b00, A_SUB);
          retire();
        end
      end
      7'h37: begin ctl(1'b0, 1'b0, 2'b00, 2'b11, 2'b01, A_ADD); aluwb(); end
      7'h17: begin ctl(1'b0, 1'b0, 2'b00, 2'b01, 2'b01, A_ADD); aluwb(); end
      default: begin
        m_trap  = 1'b1;
        m_cause = 2'b01;
      end
    endcase
  endfunction

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = rnd();
      #1;
      check("reset_strobes", {mem_req, pc_write, MemWrite, IRWrite, RegWrite}, 5'b00000);
      @(posedge clk); #1;
    end
    reset     = 1'b0;
    m_instret = 0;
    m_trap    = 1'b0;
    m_cause   = 2'b00;
  endtask

  task automatic run_queue(bit allow_rst);
    cyc_t c;
    while (q.size() > 0) begin
      if (allow_rst && $urandom_range(0, 79) == 0) begin
        q.delete();
        do_reset(1);
      end else begin
        c = q.pop_front();
        mem_ready = c.rdy;
        #1;
        check("cycle", obs(), c.outs);
        @(posedge clk); #1;
      end
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  fl;
    int          cyc;
    logic [3:0]  alu3;
    logic        pcw3;
    logic [1:0]  cause;
  } vec_t;

  vec_t vt[20];
  logic [6:0] ops[11];
  int rw_cnt, fin, nmw, got_cyc, df, dm;
  logic [3:0] got_alu, st0, fl;
  logic got_pcw;
  logic [31:0] ins;

  initial begin
    // {ins, {zero,negative,overflow,carry}, cycles to retire (0 = trap), ALUControl and pc_write on cycle 3, trap_cause}
    vt[0]  = '{32'h002081B3, 4'b0000, 4, 4'h0, 1'b0, 2'b00};
    vt[1]  = '{32'h402081B3, 4'b0000, 4, 4'h1, 1'b0, 2'b00};
    vt[2]  = '{32'h4020D1B3, 4'b0000, 4, 4'h7, 1'b0, 2'b00};
    vt[3]  = '{32'h0020B1B3, 4'b0000, 4, 4'h9, 1'b0, 2'b00};
    vt[4]  = '{32'hC0008193, 4'b0000, 4, 4'h0, 1'b0, 2'b00};
    vt[5]  = '{32'h4030D193, 4'b0000, 4, 4'h7, 1'b0, 2'b00};
    vt[6]  = '{32'h0000E193, 4'b0000, 4, 4'h3, 1'b0, 2'b00};
    vt[7]  = '{32'h00208063, 4'b1000, 3, 4'h1, 1'b1, 2'b00};
    vt[8]  = '{32'h0020E063, 4'b0001, 3, 4'h1, 1'b0, 2'b00};
    vt[9]  = '{32'h0020C063, 4'b0110, 3, 4'h1, 1'b0, 2'b00};
    vt[10] = '{32'h0020D063, 4'b0100, 3, 4'h1, 1'b0, 2'b00};
    vt[11] = '{32'h00209063, 4'b0000, 3, 4'h1, 1'b1, 2'b00};
    vt[12] = '{32'h000011B7, 4'b0000, 4, 4'h0, 1'b0, 2'b00};
    vt[13] = '{32'h0000006F, 4'b0000, 4, 4'h0, 1'b1, 2'b00};
    vt[14] = '{32'h00008067, 4'b0000, 5, 4'h0, 1'b0, 2'b00};
    vt[15] = '{32'h0000A183, 4'b0000, 5, 4'h0, 1'b0, 2'b00};
    vt[16] = '{32'h0030A023, 4'b0000, 4, 4'h0, 1'b0, 2'b00};
    vt[17] = '{32'h00000000, 4'b0000, 0, 4'h0, 1'b0, 2'b01};
    vt[18] = '{32'h0020A063, 4'b0000, 0, 4'h1, 1'b0, 2'b01};
    vt[19] = '{32'h00001197, 4'b0000, 4, 4'h0, 1'b0, 2'b00};
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h67, 7'h63, 7'h37, 7'h17, 7'h00, 7'h7F};

    reset = 1'b1; mem_ready = 1'b0; instruction = 32'h0;
    {zero, negative, overflow, carry} = 4'b0000;
    @(posedge clk); #1;

    // Reset, first fetch and a zero-wait add
    do_reset(2);
    instruction = 32'h002081B3; mem_ready = 1'b1;
    st0 = 4'h0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (c == 1) begin
        check("first_fetch", {mem_req, IRWrite, pc_write}, 3'b111);
        check("reset_instret_trap", {instret, trap, trap_cause}, 5'b00000);
        st0 = state;
      end
      if (c == 2) begin
        check("decode_strobes", {mem_req, IRWrite, pc_write}, 3'b000);
        check("state_advance", state != st0, 1'b1);
      end
      check("add_regwrite", RegWrite, c == 4);
      if (c == 4) check("add_resultsrc", ResultSrc, 2'b00);
      @(posedge clk); #1;
    end
    check("add_instret", instret, 2'd1);

    // lw with three wait cycles on fetch and on the data read
    do_reset(1);
    instruction = 32'h0000A183;
    fin = 0;
    for (int c = 1; c <= 20; c++) begin
      mem_ready = (c == 4 || c == 10);
      #1;
      check("lw_irwrite", IRWrite, c == 4);
      check("lw_regwrite", RegWrite, c == 11);
      @(posedge clk); #1;
      if (instret != 2'd0) begin
        fin = c;
        break;
      end
    end
    check("lw_cycles", fin, 11);

    // Store whose memory never answers
    do_reset(1);
    instruction = 32'h0030A023;
    nmw = 0;
    for (int c = 1; c <= 12; c++) begin
      mem_ready = (c == 1);
      #1;
      if (MemWrite) nmw++;
      @(posedge clk); #1;
    end
    check("timeout_memwrite_cycles", nmw, 5);
    check("timeout_trap", {trap, trap_cause}, 3'b110);
    check("timeout_strobes", {mem_req, pc_write, MemWrite, IRWrite, RegWrite}, 5'b00000);
    do_reset(1);
    mem_ready = 1'b1;
    #1;
    check("timeout_cleared", {trap, trap_cause, mem_req}, 4'b0001);
    @(posedge clk); #1;

    // Counter wrap with five adds, then an illegal opcode
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      instruction = 32'h002081B3;
      build(32'h002081B3, 4'b0000, 0, 0);
      run_queue(1'b0);
    end
    check("wrap_instret", instret, 2'd1);
    instruction = 32'h00000000;
    build(32'h00000000, 4'b0000, 0, 0);
    run_queue(1'b0);
    check("illegal_instret", instret, 2'd1);
    check("illegal_cause", {trap, trap_cause}, 3'b101);

    // Directed vector table with zero-wait memory
    for (int i = 0; i < 20; i++) begin
      do_reset(1);
      instruction = vt[i].ins;
      {zero, negative, overflow, carry} = vt[i].fl;
      mem_ready = 1'b1;
      got_cyc = 0; got_alu = 4'hF; got_pcw = 1'bx;
      for (int c = 1; c <= 12; c++) begin
        #1;
        if (c == 3) begin
          got_alu = ALUControl;
          got_pcw = pc_write;
        end
        @(posedge clk); #1;
        if (instret != 2'd0) begin
          got_cyc = c;
          break;
        end
        if (trap && c >= 3) break;
      end
      check($sformatf("vec%0d_cycles", i), got_cyc, vt[i].cyc);
      check($sformatf("vec%0d_alu", i), got_alu, vt[i].alu3);
      check($sformatf("vec%0d_pcw", i), got_pcw, vt[i].pcw3);
      check($sformatf("vec%0d_cause", i), trap_cause, vt[i].cause);
    end

    // Randomized instruction stream with random waits, timeouts and resets
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      ins = $urandom();
      ins[6:0] = ops[$urandom_range(0, 10)];
      fl = 4'($urandom_range(0, 15));
      df = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 2);
      dm = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
      instruction = ins;
      {zero, negative, overflow, carry} = fl;
      build(ins, fl, df, dm);
      if (m_trap) begin
        for (int k = 0; k < 2; k++) ctl(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD);
      end
      run_queue(1'b1);
      if (m_trap) do_reset(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
